// File: rtl/control_contador_if.sv
// control_contador bus: host controls plus the attached counter's
// value in, the counter clear and status flags out.
interface control_contador_if #(
  parameter int NBITS = 4,
  parameter int VBITS = 8
);
  logic             start;
  logic             stop;
  logic             modo;
  logic [NBITS-1:0] limite;
  logic [NBITS-1:0] cuenta;
  logic             clr;
  logic             fin;
  logic             ocupado;
  logic [VBITS-1:0] vueltas;
  logic [7:0]       errores;

  modport master (
    output start, stop, modo, limite, cuenta,
    input  clr, fin, ocupado, vueltas, errores
  );

  modport slave (
    input  start, stop, modo, limite, cuenta,
    output clr, fin, ocupado, vueltas, errores
  );
endinterface

// File: rtl/control_contador.sv
// Run/stop sequencer for an external contador; one-shot or periodic.
// CONTROL_CHECK_EN adds a sequence checker that drives errores.
module control_contador #(
  parameter int NBITS = 4,
  parameter int VBITS = 8
) (
  input logic            clk,
  input logic            reset,
  control_contador_if.slave bus
);

  typedef enum logic {IDLE, RUN} st_e;

  st_e              st_q, st_d;
  logic [NBITS-1:0] lim_q, lim_d;
  logic             modo_q, modo_d;
  logic             fin_q, fin_d;
  logic [VBITS-1:0] vue_q, vue_d;
  logic             hit;
  logic             go;

  assign hit = (bus.cuenta == lim_q);
  assign go  = bus.start & ~bus.stop;

  // Next state: start from IDLE, stop or terminal match from RUN
  always_comb begin
    st_d   = st_q;
    lim_d  = lim_q;
    modo_d = modo_q;
    fin_d  = 1'b0;
    vue_d  = vue_q;
    unique case (st_q)
      IDLE: begin
        if (go) begin
          st_d   = RUN;
          lim_d  = bus.limite;
          modo_d = bus.modo;
          vue_d  = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          st_d = IDLE;
        end else if (hit) begin
          fin_d = 1'b1;
          if (vue_q != '1)
            vue_d = vue_q + 1'b1;
          if (!modo_q)
            st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= IDLE;
      lim_q  <= '0;
      modo_q <= 1'b0;
      fin_q  <= 1'b0;
      vue_q  <= '0;
    end else begin
      st_q   <= st_d;
      lim_q  <= lim_d;
      modo_q <= modo_d;
      fin_q  <= fin_d;
      vue_q  <= vue_d;
    end
  end

  assign bus.clr     = (st_q == IDLE) | bus.stop | hit;
  assign bus.fin     = fin_q;
  assign bus.ocupado = (st_q == RUN);
  assign bus.vueltas = vue_q;

`ifdef CONTROL_CHECK_EN
  logic [NBITS-1:0] pcnt_q;
  logic             pclr_q;
  logic             prun_q;
  logic [7:0]       err_q, err_d;
  logic [NBITS-1:0] exp_cnt;
  logic             bad;

  assign exp_cnt = pclr_q ? '0 : NBITS'(pcnt_q + 1'b1);
  assign bad     = prun_q & (bus.cuenta != exp_cnt);

  // Error count: cleared by an accepted start, else saturating bump
  always_comb begin
    err_d = err_q;
    if (st_q == IDLE && go)
      err_d = '0;
    else if (bad && err_q != 8'hFF)
      err_d = err_q + 8'd1;
  end

  // Remember last cycle's count, clear and run state for the check
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q <= '0;
      pclr_q <= 1'b1;
      prun_q <= 1'b0;
      err_q  <= '0;
    end else begin
      pcnt_q <= bus.cuenta;
      pclr_q <= bus.clr;
      prun_q <= (st_q == RUN);
      err_q  <= err_d;
    end
  end

  assign bus.errores = err_q;
`else
  assign bus.errores = '0;
`endif

endmodule

// File: tb/tb_control_contador.sv
// Self-checking bench for control_contador with a behavioural
// counter attached and a spec-level reference model.
module tb_control_contador;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  control_contador_if #(.NBITS(4), .VBITS(8)) bus ();

  control_contador #(.NBITS(4), .VBITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  bit       m_run;
  bit       m_modo;
  bit [3:0] m_lim;
  bit       m_fin;
  int       m_vue;
  int       m_err;
  bit       m_clr;
  bit       pend;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_run = 0; m_modo = 0; m_lim = 0;
    m_fin = 0; m_vue = 0; m_err = 0; pend = 0;
  endtask

  task automatic cyc(input bit st, input bit sp, input bit md,
                     input bit [3:0] lm, input bit skip = 0);
    bit was_run;
    bit [3:0] c;
    bus.start  = st;
    bus.stop   = sp;
    bus.modo   = md;
    bus.limite = lm;
    #1;
    c     = bus.cuenta;
    m_clr = !m_run || sp || (c == m_lim);
    chk("clr",     bus.clr,     m_clr);
    chk("fin",     bus.fin,     m_fin);
    chk("ocupado", bus.ocupado, m_run);
    chk("vueltas", bus.vueltas, m_vue);
    chk("errores", bus.errores, m_err);
    was_run = m_run;
    @(posedge clk);
    if (reset) begin
`ifdef CONTROL_CHECK_EN
      if (pend && m_err < 255) m_err++;
`endif
      pend  = 0;
      m_fin = 0;
      if (!m_run) begin
        if (st && !sp) begin
          m_run = 1; m_lim = lm; m_modo = md;
          m_vue = 0; m_err = 0;
        end
      end else if (sp) begin
        m_run = 0;
      end else if (c == m_lim) begin
        m_fin = 1;
        if (m_vue < 255) m_vue++;
        if (!m_modo) m_run = 0;
      end
    end
    #1;
    bus.cuenta = m_clr ? 4'd0 : c + 4'd1 + (skip ? 4'd1 : 4'd0);
    if (skip && was_run) pend = 1;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.start = 0; bus.stop = 0; bus.modo = 0;
    bus.limite = 0; bus.cuenta = 0;
    m_reset();
    #2;
    chk("rst_clr",     bus.clr,     1);
    chk("rst_ocupado", bus.ocupado, 0);
    chk("rst_fin",     bus.fin,     0);
    chk("rst_vueltas", bus.vueltas, 0);
    chk("rst_errores", bus.errores, 0);
    @(negedge clk);
    reset = 1'b1;

    // periodic, limite 3
    cyc(1, 0, 1, 3);
    for (int i = 0; i < 12; i++)
      cyc(0, 0, 0, 4'($urandom));
    chk("t1_vueltas", bus.vueltas, 3);
    chk("t1_ocupado", bus.ocupado, 1);
    cyc(0, 1, 0, 0);

    // one-shot, limite 5
    cyc(1, 0, 0, 5);
    for (int i = 0; i < 8; i++)
      cyc(0, 0, 1, 4'($urandom));
    chk("t2_vueltas", bus.vueltas, 1);
    chk("t2_ocupado", bus.ocupado, 0);
    chk("t2_cuenta",  bus.cuenta,  0);

    // stop mid period, then start+stop together
    cyc(1, 0, 1, 7);
    cyc(0, 0, 1, 7);
    cyc(0, 0, 1, 7);
    chk("t3_cuenta2", bus.cuenta, 2);
    cyc(0, 1, 1, 7);
    chk("t3_ocupado", bus.ocupado, 0);
    chk("t3_cuenta0", bus.cuenta,  0);
    chk("t3_fin",     bus.fin,     0);
    cyc(1, 1, 1, 7);
    chk("t3_both",    bus.ocupado, 0);

    // limite 0 periodic, saturation
    cyc(1, 0, 1, 0);
    for (int i = 0; i < 260; i++)
      cyc(0, 0, 0, 4'($urandom));
    chk("t4_vueltas", bus.vueltas, 255);
    chk("t4_fin",     bus.fin,     1);
    cyc(0, 1, 0, 0);

    // async reset mid-run
    cyc(1, 0, 1, 4);
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 1, 4);
    chk("t5_pre_fin", bus.fin, 1);
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    chk("t5_clr",     bus.clr,     1);
    chk("t5_fin",     bus.fin,     0);
    chk("t5_ocupado", bus.ocupado, 0);
    chk("t5_vueltas", bus.vueltas, 0);
    chk("t5_errores", bus.errores, 0);
    @(negedge clk);
    cyc(1, 0, 1, 3);
    cyc(1, 0, 1, 3);
    reset = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 3);
    chk("t5_idle", bus.ocupado, 0);

    // sequence skip during run
    cyc(1, 0, 1, 7);
    cyc(0, 0, 1, 7);
    cyc(0, 0, 1, 7, 1);
    chk("t6_cuenta3", bus.cuenta, 3);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 7);
`ifdef CONTROL_CHECK_EN
    chk("t6_errores", bus.errores, 1);
`else
    chk("t6_errores", bus.errores, 0);
`endif
    cyc(0, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) == 0, ($urandom % 16) == 0,
          1'($urandom), 4'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_contador.md
Name: control_contador

Overview:
- Sequencing controller for one `contador` instance (parameter `nbits`, ports `clk`, `reset`, `out`).
- Drives the counter's active-high clear from a run/stop FSM and a programmable terminal value; the attached counter provides the count.
- Supports one-shot and periodic operation, reports completed periods and an end-of-period pulse.
- Sits between a host/control bus and the counter; replaces ad-hoc clear logic around counters.

Parameters:
- NBITS, 4, width of the attached counter and of `limite`/`cuenta`.
- VBITS, 8, width of the completed-period counter `vueltas`.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  level sampled each edge; begins a run from IDLE.
- stop  in  1  level sampled each edge; aborts a run.
- modo  in  1  0 = one-shot, 1 = periodic; latched at start.
- limite  in  NBITS  terminal count; latched at start into `limite_q`.
- cuenta  in  NBITS  current value from the attached counter's `out`.
- clr  out  1  active-high clear to the attached counter's `reset`.
- fin  out  1  one-cycle pulse per completed period.
- ocupado  out  1  high while in RUN.
- vueltas  out  VBITS  completed periods in current/last run.
- errores  out  8  sequence-error count (see optional feature).

Behaviour:
- Counter contract: at each edge the attached counter loads 0 if `clr`=1, else `cuenta`+1 mod 2^NBITS.
- FSM has two states, IDLE and RUN. The reset state is IDLE.
- Reset (async, `reset`=0):
  - state=IDLE; `fin`=0, `ocupado`=0, `vueltas`=0, `errores`=0, `limite_q`=0, `modo_q`=0.
  - `clr`=1 throughout reset.
- `clr` is combinational: `clr` = (state==IDLE) | stop | (cuenta==limite_q). It is the only combinational output; all others are registered.
- IDLE:
  - `clr`=1, so the counter is held at 0.
  - `start`=1 and `stop`=0 at an edge causes: go to RUN; latch `limite`/`modo`; clear `vueltas`.
  - `start` and `stop` high together: stop wins and the FSM stays in IDLE.
- RUN:
  - `ocupado`=1. The counter sequence is 0,1,…,limite_q, so the period is limite_q+1 cycles.
  - Match edge (`cuenta`==`limite_q`, `stop`=0):
    - `fin`=1 for the next cycle.
    - `vueltas`+1, saturating at 2^VBITS-1.
    - Counter cleared by `clr` at that same edge.
    - `modo_q`=1: stay in RUN. `modo_q`=0: go to IDLE.
  - `stop`=1 at an edge: go to IDLE, counter cleared at that edge, no `fin`, `vueltas` unchanged.
  - `start` is ignored while in RUN. Changes to `limite`/`modo` mid-run have no effect.
- Boundary conditions:
  - `limite`=0: `clr` stays 1 in RUN. Periodic mode gives `fin` every cycle. One-shot mode gives a single `fin` and returns to IDLE after 1 cycle.
  - `limite`=2^NBITS-1: full-range period of 2^NBITS cycles.
- `reset` asserted mid-run returns everything to reset values immediately. Operation resumes only on a new `start` after release.

Optional Feature:
- Macro: CONTROL_CHECK_EN.
- Defined:
  - Controller registers the previous `cuenta` and previous `clr`.
  - Check applies in every cycle where the previous cycle was RUN: expected `cuenta` = 0 if previous `clr`=1, else previous `cuenta`+1 mod 2^NBITS.
  - A mismatch increments `errores`, saturating at 255.
  - `errores` clears on reset and on accepted `start`.
- Not defined: `errores` is tied to 0 and no check logic is synthesized. Port list is identical in both builds.

Test Plan:
1. Periodic run: NBITS=4, `limite`=3, `modo`=1, `start` for 1 cycle → `cuenta` 0,1,2,3,0,1,2,3,0…; `fin` one cycle after each 3; after 3 periods `vueltas`=3; `ocupado`=1 throughout.
2. One-shot run: `limite`=5, `modo`=0, `start` → `cuenta` 0..5; single `fin`; then IDLE with `ocupado`=0, `clr`=1, `cuenta` held 0, `vueltas`=1.
3. Mid-period stop: `limite`=7, periodic; `stop`=1 when `cuenta`=2 → `clr`=1 that cycle; next `cuenta`=0; state IDLE; no `fin`; `vueltas` unchanged. Also `start`+`stop` together in IDLE → stays IDLE.
4. Degenerate limit: `limite`=0, periodic, VBITS=8 → `clr` constant 1, `fin` every cycle, `vueltas` saturates at 255 after 255 periods and holds.
5. Async reset: assert `reset`=0 at `cuenta`=4 mid-edge → `fin`, `ocupado`, `vueltas`, `errores` go 0 and `clr` goes 1 without waiting for `clk`; after release the FSM stays IDLE until `start`.
6. With CONTROL_CHECK_EN: drive `cuenta` 0,1,3 (skip) during RUN, `limite`=7 → `errores`=1; clean sequence → `errores` stays 0. Without the macro, `errores`=0 always.
